mdu_iter: RTL and testbench

Iterative RV32M multiply/divide unit sitting beside the combinational ALU in the execute stage. It is the multi-cycle side of the execute interface: the core issues an operation with a start pulse, stalls on `busy`, and takes the 32-bit result on the `done` pulse. It covers all eight RV32M operations with one shared 64-bit shift datapath, one bit per cycle.

---
 rtl/mdu_iter.sv | 170 +++++++++++++++++
 tb/tb_mdu_iter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit, one bit per cycle on a shared 64-bit datapath.
// Define MDU_DIV_EN to build the divider; without it divide ops complete early with C=0.
module mdu_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] C,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t      state;
  logic [2:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        sa;
  logic        sb;
  logic [63:0] work;
  logic [4:0]  cnt;
  logic        special;
  logic [31:0] spec_c;

  logic        sgn_a;
  logic        sgn_b;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        spec_hit;
  logic [31:0] spec_val;
  logic [32:0] mul_sum;
  logic [63:0] mul_step;
  logic [63:0] step;
  logic [63:0] prod;
  logic [31:0] mul_res;
  logic [31:0] fix_res;

  assign sgn_a = (op_q == 3'b001) || (op_q == 3'b010) ||
                 (op_q == 3'b100) || (op_q == 3'b110);
  assign sgn_b = (op_q == 3'b001) || (op_q == 3'b100) ||
                 (op_q == 3'b110);

  assign a_neg = sgn_a & a_q[31];
  assign b_neg = sgn_b & b_q[31];
  assign a_mag = a_neg ? (~a_q + 32'd1) : a_q;
  assign b_mag = b_neg ? (~b_q + 32'd1) : b_q;

  // Product bits drop into the low half as the accumulator shifts right.
  assign mul_sum  = {1'b0, work[63:32]} +
                    (b_q[cnt] ? {1'b0, a_q} : 33'd0);
  assign mul_step = {mul_sum, work[31:1]};

  assign prod    = (sa ^ sb) ? (~work + 64'd1) : work;
  assign mul_res = (op_q == 3'b000) ? prod[31:0] : prod[63:32];

`ifdef MDU_DIV_EN
  logic [32:0] r_sh;
  logic        ge;
  logic [31:0] diff;
  logic [63:0] div_step;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] div_res;

  // Remainder lives in work[63:32], quotient shifts in at work[0].
  assign r_sh     = {work[63:32], a_q[~cnt]};
  assign ge       = r_sh >= {1'b0, b_q};
  assign diff     = r_sh[31:0] - b_q;
  assign div_step = ge ? {diff, work[30:0], 1'b1}
                       : {r_sh[31:0], work[30:0], 1'b0};
  assign step     = op_q[2] ? div_step : mul_step;

  assign quo     = (sa ^ sb) ? (~work[31:0] + 32'd1) : work[31:0];
  assign rem     = sa ? (~work[63:32] + 32'd1) : work[63:32];
  assign div_res = op_q[1] ? rem : quo;
  assign fix_res = op_q[2] ? div_res : mul_res;

  always_comb begin
    spec_hit = 1'b0;
    spec_val = 32'd0;
    if (op_q[2]) begin
      if (b_q == 32'd0) begin
        spec_hit = 1'b1;
        spec_val = op_q[1] ? a_q : 32'hFFFF_FFFF;
      end else if (!op_q[0] && a_q == 32'h8000_0000 &&
                   b_q == 32'hFFFF_FFFF) begin
        spec_hit = 1'b1;
        spec_val = op_q[1] ? 32'd0 : 32'h8000_0000;
      end
    end
  end
`else
  assign step     = mul_step;
  assign fix_res  = mul_res;
  assign spec_hit = op_q[2];
  assign spec_val = 32'd0;
`endif

  // Special cases still pass through FIX so done lands two edges after accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      sa      <= 1'b0;
      sb      <= 1'b0;
      work    <= 64'd0;
      cnt     <= 5'd0;
      special <= 1'b0;
      spec_c  <= 32'd0;
      C       <= 32'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op;
            a_q   <= A;
            b_q   <= B;
            busy  <= 1'b1;
            state <= PREP;
          end
        end
        PREP: begin
          sa      <= a_neg;
          sb      <= b_neg;
          a_q     <= a_mag;
          b_q     <= b_mag;
          work    <= 64'd0;
          cnt     <= 5'd0;
          special <= spec_hit;
          spec_c  <= spec_val;
          state   <= spec_hit ? FIX : CALC;
        end
        CALC: begin
          work <= step;
          cnt  <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          C     <= special ? spec_c : fix_res;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: scoreboard of expected results and latencies.
// Expected values follow MDU_DIV_EN in the same way as the design build.
module tb_mdu_iter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic [31:0] c_o;
  logic        busy;
  logic        done;

  int passed = 0;
  int total  = 0;

  logic [31:0] exp_q[$];
  int          lat_q[$];

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  mdu_iter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op_i),
    .A     (a_i),
    .B     (b_i),
    .C     (c_o),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] dexp(input logic [31:0] v);
    return DIV_EN ? v : 32'd0;
  endfunction

  function automatic int dlat(input int normal);
    return DIV_EN ? normal : 2;
  endfunction

  // Issue one op, optionally poke start during CALC, then check on done.
  task automatic run_op(input string tag, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat,
                        input int poke);
    int k;
    logic busy_ok;
    logic [31:0] e;
    int l;
    op_i  = o;
    a_i   = a;
    b_i   = b;
    start = 1'b1;
    exp_q.push_back(exp);
    lat_q.push_back(lat);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, "_busy_acc"}, {31'd0, busy}, 32'd1);
    k = 0;
    busy_ok = 1'b1;
    while (!done && k < 60) begin
      if (k == poke) begin
        start = 1'b1;
        op_i  = 3'b101;
        a_i   = 32'h0000_1234;
        b_i   = 32'd3;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      k++;
      if (!done && !busy) busy_ok = 1'b0;
    end
    e = exp_q.pop_front();
    l = lat_q.pop_front();
    chk({tag, "_busy_run"}, {31'd0, busy_ok}, 32'd1);
    chk({tag, "_lat"}, 32'(k), 32'(l));
    chk({tag, "_C"}, c_o, e);
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0;
    start = 1'b1;
    op_i  = 3'b000;
    a_i   = 32'd7;
    b_i   = 32'd3;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_C", c_o, 32'd0);
    rst_n = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_busy", {31'd0, busy}, 32'd0);

    run_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 5);
    run_op("mul_ff", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 34, -1);
    run_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000,
           32'h4000_0000, 34, -1);
    run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 34, -1);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 34, -1);
    run_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2,
           dexp(32'hFFFF_FFFD), dlat(34), -1);
    run_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2,
           dexp(32'hFFFF_FFFF), dlat(34), -1);
    run_op("divu", 3'b101, 32'd100, 32'd7, dexp(32'd14), dlat(34), -1);
    run_op("remu", 3'b111, 32'd100, 32'd7, dexp(32'd2), dlat(34), -1);
    run_op("div_nn", 3'b100, 32'hFFFF_FFF8, 32'hFFFF_FFFE,
           dexp(32'd4), dlat(34), -1);
    run_op("rem_pn", 3'b110, 32'd7, 32'hFFFF_FFFE,
           dexp(32'd1), dlat(34), -1);
    run_op("divu0", 3'b101, 32'd5, 32'd0, dexp(32'hFFFF_FFFF), 2, -1);
    run_op("remu0", 3'b111, 32'd5, 32'd0, dexp(32'd5), 2, -1);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF,
           dexp(32'h8000_0000), 2, -1);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF,
           32'd0, 2, -1);

    // Abort a multiply while count is 10.
    op_i  = 3'b000;
    a_i   = 32'd9;
    b_i   = 32'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    chk("abort_busy_pre", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_C", c_o, 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    chk("abort_quiet", 32'(seen), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
